// File: rtl/bk_periph_pkg.sv
// Shared definitions for the BK peripheral register blocks: interrupt
// controller register offsets, ack FSM encoding and the vector helper.
package bk_periph_pkg;

    localparam int unsigned REG_AW = 5;

    // Byte offsets within the controller's register window (octal).
    localparam logic [REG_AW-1:0] INTC_ENABLE  = 5'o00;
    localparam logic [REG_AW-1:0] INTC_PENDING = 5'o02;
    localparam logic [REG_AW-1:0] INTC_MODE    = 5'o04;
    localparam logic [REG_AW-1:0] INTC_STATUS  = 5'o06;
    localparam logic [REG_AW-1:0] INTC_VEC0    = 5'o20;

    // Acknowledge FSM encoding.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    // Default vector of a channel: base + 4*index, 16-bit wrap.
    function automatic logic [15:0] chan_vec(input logic [15:0] base,
                                             input logic [2:0]  idx);
        return base + {11'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Lowest-index-first priority encoder over eight request bits.
//   req     : request vector, bit 0 has the highest priority
//   valid_c : any request present
//   index_c : index of the winning request (0 when none)
module prio_enc8 (
    input  logic [7:0] req,
    output logic       valid_c,
    output logic [2:0] index_c
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        valid_c = |req;
        index_c = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) index_c = 3'(i);
        end
    end

endmodule

// File: rtl/vintc_arbiter.sv
// Vectored interrupt controller for the BK core: collects NCHAN sources,
// drives VIRQ, resolves fixed priority and supplies the vector during IAKO.
// Optional feature macro: INTC_VECTOR_REGS_EN (per-channel R/W vector regs).
// Ports:
//   clk, reset_n   : core clock, asynchronous active-low reset
//   ce             : clock enable, all state advances only when high
//   irq_i          : per-channel requests, active-high
//   iako_i         : CPU interrupt acknowledge
//   regwr, regrd   : register write / read strobes
//   addr, data_i   : register word offset (addr[0] ignored) and write data
//   data_o         : register read data, combinational from addr
//   virq_o         : registered interrupt request to the CPU
//   vector_o       : vector of the acknowledged channel
//   ack_chan_o     : index of the acknowledged channel
module vintc_arbiter #(
    parameter int unsigned NCHAN        = 4,
    parameter logic [15:0] VEC_BASE     = 16'o000300,
    parameter logic [15:0] SPUR_VEC     = 16'o000000,
    parameter logic [7:0]  EDGE_DEFAULT = 8'hFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic [NCHAN-1:0] irq_i,
    input  logic             iako_i,
    input  logic             regwr,
    input  logic             regrd,
    input  logic [4:0]       addr,
    input  logic [15:0]      data_i,
    output logic [15:0]      data_o,
    output logic             virq_o,
    output logic [15:0]      vector_o,
    output logic [2:0]       ack_chan_o
);
    import bk_periph_pkg::*;

    logic [NCHAN-1:0] enable_q, pending_q, mode_q, sample_q;
    logic [NCHAN-1:0] pending_n, pend_clr, pend_en;
    logic [0:0]       state_q, state_n;
    logic             ack_valid_q, ack_take, ack_done;
    logic             win_valid;
    logic [2:0]       win_idx;
    logic [15:0]      win_vec;
    logic [4:0]       reg_off;

    assign reg_off = {addr[4:1], 1'b0};
    assign pend_en = pending_q & enable_q;

    // Strobe and bits intentionally not decoded.
    logic unused_sink;
    assign unused_sink = &{1'b0, regrd, addr[0], data_i};

    // One encoder serves both STATUS and the ack latch.
    prio_enc8 u_prio (
        .req     (8'(pend_en)),
        .valid_c (win_valid),
        .index_c (win_idx)
    );

`ifdef INTC_VECTOR_REGS_EN
    logic [15:0] vec_q [NCHAN];

    // Programmable vectors, low two bits forced to word alignment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NCHAN); i++) vec_q[i] <= chan_vec(VEC_BASE, 3'(i));
        end else if (ce) begin
            for (int i = 0; i < int'(NCHAN); i++) begin
                if (regwr && reg_off == INTC_VEC0 + 5'(2 * i)) vec_q[i] <= {data_i[15:2], 2'b00};
            end
        end
    end

    // Vector of the current winner.
    always_comb begin
        win_vec = vec_q[0];
        for (int i = 0; i < int'(NCHAN); i++) begin
            if (3'(i) == win_idx) win_vec = vec_q[i];
        end
    end
`else
    assign win_vec = chan_vec(VEC_BASE, win_idx);
`endif

    // Ack FSM next-state: latch on IAKO rise, release and clear on IAKO fall.
    always_comb begin
        state_n  = state_q;
        ack_take = 1'b0;
        ack_done = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE: if (iako_i) begin
                    state_n  = ACK;
                    ack_take = 1'b1;
                end
                ACK: if (!iako_i) begin
                    state_n  = IDLE;
                    ack_done = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Pending next value: edge channels set on rising sample (set beats any
    // clear), level channels simply track the input.
    always_comb begin
        pend_clr = '0;
        if (regwr && reg_off == INTC_PENDING) pend_clr = data_i[NCHAN-1:0];
        for (int i = 0; i < int'(NCHAN); i++) begin
            if (ack_done && ack_valid_q && 3'(i) == ack_chan_o) pend_clr[i] = 1'b1;
        end
        for (int i = 0; i < int'(NCHAN); i++) begin
            pending_n[i] = mode_q[i] ? ((~sample_q[i] & irq_i[i]) | (pending_q[i] & ~pend_clr[i]))
                                     : irq_i[i];
        end
    end

    // State, registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            enable_q    <= '0;
            pending_q   <= '0;
            mode_q      <= EDGE_DEFAULT[NCHAN-1:0];
            sample_q    <= '0;
            ack_valid_q <= 1'b0;
            virq_o      <= 1'b0;
            vector_o    <= SPUR_VEC;
            ack_chan_o  <= 3'd0;
        end else if (ce) begin
            state_q   <= state_n;
            sample_q  <= irq_i;
            pending_q <= pending_n;
            virq_o    <= |pend_en;
            if (regwr && reg_off == INTC_ENABLE) enable_q <= data_i[NCHAN-1:0];
            if (regwr && reg_off == INTC_MODE)   mode_q   <= data_i[NCHAN-1:0];
            if (ack_take) begin
                ack_valid_q <= win_valid;
                ack_chan_o  <= win_valid ? win_idx : 3'd0;
                vector_o    <= win_valid ? win_vec : SPUR_VEC;
            end
        end
    end

    // Register read mux; anything unmapped reads all ones.
    always_comb begin
        data_o = 16'o177777;
        case (reg_off)
            INTC_ENABLE:  data_o = 16'(enable_q);
            INTC_PENDING: data_o = 16'(pending_q);
            INTC_MODE:    data_o = 16'(mode_q);
            INTC_STATUS:  data_o = {win_valid, 12'd0, win_idx};
            default: ;
        endcase
`ifdef INTC_VECTOR_REGS_EN
        for (int i = 0; i < int'(NCHAN); i++) begin
            if (reg_off == INTC_VEC0 + 5'(2 * i)) data_o = vec_q[i];
        end
`endif
    end

endmodule

// File: tb/tb_vintc_arbiter.sv
// Directed bench for vintc_arbiter (NCHAN=4, default parameters).
module tb_vintc_arbiter;

    logic        clk, reset_n, ce, iako_i, regwr, regrd;
    logic [3:0]  irq_i;
    logic [4:0]  addr;
    logic [15:0] data_i, data_o, vector_o;
    logic        virq_o;
    logic [2:0]  ack_chan_o;

    int checks = 0;
    int errors = 0;

    vintc_arbiter #(.NCHAN(4)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .irq_i(irq_i), .iako_i(iako_i),
        .regwr(regwr), .regrd(regrd), .addr(addr), .data_i(data_i), .data_o(data_o),
        .virq_o(virq_o), .vector_o(vector_o), .ack_chan_o(ack_chan_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  ra;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [14];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06o expected %06o", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
        addr   = a;
        data_i = d;
        regwr  = 1'b1;
        tick();
        regwr  = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [15:0] exp);
        addr  = a;
        regrd = 1'b1;
        #1;
        chk(nm, data_o, exp);
        regrd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; ce = 1'b1; iako_i = 1'b0; regwr = 1'b0; regrd = 1'b0;
        irq_i = 4'b0; addr = 5'o00; data_i = 16'h0;

        vecs[0]  = '{1'b0, 5'o00, 16'o0,      5'o00, 16'o000000};
        vecs[1]  = '{1'b0, 5'o00, 16'o0,      5'o02, 16'o000000};
        vecs[2]  = '{1'b0, 5'o00, 16'o0,      5'o04, 16'o000017};
        vecs[3]  = '{1'b0, 5'o00, 16'o0,      5'o06, 16'o000000};
        vecs[4]  = '{1'b0, 5'o00, 16'o0,      5'o10, 16'o177777};
`ifdef INTC_VECTOR_REGS_EN
        vecs[5]  = '{1'b0, 5'o00, 16'o0,      5'o20, 16'o000300};
        vecs[13] = '{1'b0, 5'o00, 16'o0,      5'o26, 16'o000314};
`else
        vecs[5]  = '{1'b0, 5'o00, 16'o0,      5'o20, 16'o177777};
        vecs[13] = '{1'b0, 5'o00, 16'o0,      5'o26, 16'o177777};
`endif
        vecs[6]  = '{1'b0, 5'o00, 16'o0,      5'o36, 16'o177777};
        vecs[7]  = '{1'b1, 5'o00, 16'o177777, 5'o00, 16'o000017};
        vecs[8]  = '{1'b1, 5'o04, 16'o000005, 5'o04, 16'o000005};
        vecs[9]  = '{1'b1, 5'o04, 16'o177777, 5'o05, 16'o000017};
        vecs[10] = '{1'b1, 5'o06, 16'o001234, 5'o06, 16'o000000};
        vecs[11] = '{1'b1, 5'o00, 16'o000000, 5'o01, 16'o000000};
        vecs[12] = '{1'b1, 5'o16, 16'o000777, 5'o00, 16'o000000};

        // Reset values.
        #3;
        chk("rst_virq", 16'(virq_o), 16'd0);
        chk("rst_vector", vector_o, 16'o000000);
        chk("rst_chan", 16'(ack_chan_o), 16'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Register map vectors.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) wr_reg(vecs[i].wa, vecs[i].wd);
            rd_chk($sformatf("regvec[%0d]", i), vecs[i].ra, vecs[i].exp);
        end

        // Edge IRQ on channel 2.
        wr_reg(5'o00, 16'o17);
        irq_i = 4'b0100; tick();
        chk("edge_virq_early", 16'(virq_o), 16'd0);
        rd_chk("edge_pend", 5'o02, 16'o4);
        irq_i = 4'b0; tick();
        chk("edge_virq", 16'(virq_o), 16'd1);
        iako_i = 1'b1; tick();
        chk("edge_vec", vector_o, 16'o310);
        chk("edge_chan", 16'(ack_chan_o), 16'd2);
        tick();
        chk("edge_vec_hold", vector_o, 16'o310);
        iako_i = 1'b0; tick();
        rd_chk("edge_pend_clr", 5'o02, 16'o0);
        tick();
        chk("edge_virq_off", 16'(virq_o), 16'd0);

        // Priority between channels 1 and 3.
        irq_i = 4'b1010; tick();
        irq_i = 4'b0;
        rd_chk("prio_status", 5'o06, 16'o100001);
        tick();
        iako_i = 1'b1; tick();
        chk("prio_vec1", vector_o, 16'o304);
        chk("prio_chan1", 16'(ack_chan_o), 16'd1);
        iako_i = 1'b0; tick();
        rd_chk("prio_pend", 5'o02, 16'o10);
        iako_i = 1'b1; tick();
        chk("prio_vec2", vector_o, 16'o314);
        chk("prio_chan2", 16'(ack_chan_o), 16'd3);
        iako_i = 1'b0; tick();
        tick();
        chk("prio_virq_off", 16'(virq_o), 16'd0);

        // Level mode on channel 0.
        wr_reg(5'o04, 16'o0);
        irq_i = 4'b0001; tick();
        tick();
        chk("lvl_virq", 16'(virq_o), 16'd1);
        iako_i = 1'b1; tick();
        chk("lvl_vec1", vector_o, 16'o300);
        iako_i = 1'b0; tick();
        rd_chk("lvl_pend_held", 5'o02, 16'o1);
        iako_i = 1'b1; tick();
        chk("lvl_vec2", vector_o, 16'o300);
        chk("lvl_chan2", 16'(ack_chan_o), 16'd0);
        iako_i = 1'b0; tick();
        wr_reg(5'o02, 16'o1);
        rd_chk("lvl_w1c_ignored", 5'o02, 16'o1);
        irq_i = 4'b0; tick();
        chk("lvl_virq_1ce", 16'(virq_o), 16'd1);
        tick();
        chk("lvl_virq_2ce", 16'(virq_o), 16'd0);
        wr_reg(5'o02, 16'o1);
        rd_chk("lvl_pend_zero", 5'o02, 16'o0);
        wr_reg(5'o04, 16'o17);

        // Spurious acknowledge after a software clear.
        irq_i = 4'b0001; tick();
        irq_i = 4'b0;
        wr_reg(5'o02, 16'o1);
        rd_chk("spur_pend_clr", 5'o02, 16'o0);
        iako_i = 1'b1; tick();
        chk("spur_vec", vector_o, 16'o000000);
        chk("spur_chan", 16'(ack_chan_o), 16'd0);
        chk("spur_virq", 16'(virq_o), 16'd0);
        iako_i = 1'b0; tick();
        rd_chk("spur_pend_after", 5'o02, 16'o0);

        // New edge on channel 1 in the same ce as its ack clear.
        irq_i = 4'b0010; tick();
        irq_i = 4'b0; tick();
        iako_i = 1'b1; tick();
        chk("coll_vec", vector_o, 16'o304);
        iako_i = 1'b0; irq_i = 4'b0010; tick();
        rd_chk("coll_pend", 5'o02, 16'o2);
        chk("coll_virq", 16'(virq_o), 16'd1);
        tick();
        chk("coll_virq_hold", 16'(virq_o), 16'd1);
        irq_i = 4'b0;
        wr_reg(5'o02, 16'o2);
        rd_chk("coll_cleanup", 5'o02, 16'o0);

        // Write-1-clear in the same ce as an edge on channel 3.
        irq_i = 4'b1000;
        wr_reg(5'o02, 16'o10);
        rd_chk("w1c_set_wins", 5'o02, 16'o10);
        irq_i = 4'b0;
        wr_reg(5'o02, 16'o10);
        rd_chk("w1c_clear", 5'o02, 16'o0);

        // ENABLE write during ACK leaves the latched vector alone.
        irq_i = 4'b0100; tick();
        irq_i = 4'b0;
        iako_i = 1'b1; tick();
        wr_reg(5'o00, 16'o0);
        chk("en_ack_vec", vector_o, 16'o310);
        chk("en_ack_chan", 16'(ack_chan_o), 16'd2);
        iako_i = 1'b0; tick();
        rd_chk("en_ack_pend", 5'o02, 16'o0);
        wr_reg(5'o00, 16'o17);

        // Clock enable gating.
        ce = 1'b0; irq_i = 4'b0001; tick(); tick();
        rd_chk("ce_hold", 5'o02, 16'o0);
        ce = 1'b1; tick();
        rd_chk("ce_run", 5'o02, 16'o1);
        irq_i = 4'b0;
        wr_reg(5'o02, 16'o1);

        // Asynchronous reset in the middle of an acknowledge.
        irq_i = 4'b0001; tick();
        irq_i = 4'b0; tick();
        iako_i = 1'b1; tick();
        chk("rstack_vec_pre", vector_o, 16'o300);
        chk("rstack_virq_pre", 16'(virq_o), 16'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstack_virq", 16'(virq_o), 16'd0);
        chk("rstack_vec", vector_o, 16'o000000);
        rd_chk("rstack_enable", 5'o00, 16'o0);
        rd_chk("rstack_pend", 5'o02, 16'o0);
        iako_i = 1'b0; tick();
        reset_n = 1'b1; tick();

`ifdef INTC_VECTOR_REGS_EN
        // Programmable vector for channel 1.
        wr_reg(5'o00, 16'o17);
        wr_reg(5'o22, 16'o1002);
        rd_chk("vreg_rd", 5'o22, 16'o1000);
        irq_i = 4'b0010; tick();
        irq_i = 4'b0; tick();
        iako_i = 1'b1; tick();
        chk("vreg_vec", vector_o, 16'o1000);
        chk("vreg_chan", 16'(ack_chan_o), 16'd1);
        iako_i = 1'b0; tick();
`else
        // Vector-register window stays unmapped.
        wr_reg(5'o22, 16'o1002);
        rd_chk("vreg_unmapped", 5'o22, 16'o177777);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
